chaos_keystream_xor: RTL
========================

CHAOS_KEYSTREAM_XOR -- requirements
Module: chaos_keystream_xor

Interface
REQ-001 Parameter: PRECISION, default 32, width of each chaotic state word (IEEE-754 single).
REQ-002 Parameter: KEY_DEPTH, default 16, key FIFO depth in bytes; power of two, at least 4.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  one new state triple (x0,x1,x2) from the affine stage is present this cycle.
REQ-006 x0, x1, x2  input  PRECISION each  chaotic state words, float32 bit patterns.
REQ-007 in_ready  output  1  key FIFO can accept three bytes this cycle.
REQ-008 pix_valid  input  1  plaintext pixel present.
REQ-009 pix_data  input  8  plaintext pixel byte.
REQ-010 pix_sof  input  1  qualifies pix_data as first pixel of a frame.
REQ-011 pix_last  input  1  qualifies pix_data as last pixel of a frame.
REQ-012 pix_ready  output  1  pixel accepted this cycle when high with pix_valid.
REQ-013 diffuse_en  input  1  1 selects cipher-chaining mode, 0 selects plain XOR.
REQ-014 iv  input  8  chaining seed used on the pixel with pix_sof.
REQ-015 out_valid  output  1  cipher byte present.
REQ-016 out_data  output  8  cipher byte.
REQ-017 out_last  output  1  registered copy of pix_last for the byte on out_data.
REQ-018 out_ready  input  1  downstream accepts the cipher byte.
REQ-019 overflow  output  1  sticky flag: a state triple was dropped.
REQ-020 key_level  output  $clog2(KEY_DEPTH)+1  current key FIFO occupancy in bytes.

Function
REQ-021 Key byte extraction per word x: k = x[7:0] ^ x[15:8] ^ {1'b0, x[22:16]}; sign and exponent bits are ignored.
REQ-022 On in_valid && in_ready, k(x0), k(x1), k(x2) are written in that order into the FIFO in one cycle; k(x0) is popped first.
REQ-023 in_ready = (key_level <= KEY_DEPTH-3), evaluated on the registered occupancy; it does not depend on the same-cycle pop.
REQ-024 in_valid && !in_ready: the whole triple is dropped, FIFO unchanged, overflow set to 1 the next cycle and held until reset.
REQ-025 pix_ready = (key_level != 0) && (!out_valid || out_ready).
REQ-026 Pixel transfer (pix_valid && pix_ready) pops one key byte k and loads the output register in the same edge; latency from pixel accept to out_valid is 1 cycle.
REQ-027 diffuse_en=0: out_data = pix_data ^ k.
REQ-028 diffuse_en=1: out_data = pix_data ^ k ^ c_prev, with c_prev = iv when pix_sof is high on that transfer, else the previously emitted out_data.
REQ-029 c_prev updates on every pixel transfer regardless of diffuse_en; diffuse_en is sampled per transfer.
REQ-030 out_valid holds with out_data/out_last stable until out_ready; it clears when out_ready is high and no new transfer occurs that cycle.
REQ-031 Simultaneous push (3) and pop (1) in one cycle: key_level increases by exactly 2; no byte is lost or reordered.
REQ-032 Read/write pointers wrap modulo KEY_DEPTH; key_level never exceeds KEY_DEPTH.
REQ-033 Empty FIFO: pix_ready is 0 and pixel is held by upstream; no output generated.

Reset
REQ-034 On reset: FIFO empty, key_level=0, in_ready=1, pix_ready=0, out_valid=0, out_data=0, out_last=0, overflow=0, c_prev=0.
REQ-035 Reset asserted mid-frame discards all buffered keys and any pending output byte; the first transfer after reset follows REQ-028 with the c_prev=0 default unless pix_sof is high.

Verification
REQ-036 Push x0=0x3F123456, x1=0x00000000, x2=0xBF7FFFFF -> key_level=3, key bytes 0x70, 0x00, 0x7F.
REQ-037 With REQ-036 keys, diffuse_en=0, pixels 0x11(sof), 0x22, 0x33(last), out_ready=1 -> out_data 0x61, 0x22, 0x4C, out_last on third byte only.
REQ-038 Same keys, diffuse_en=1, iv=0xA5 -> out_data 0xC4, 0xE6, 0xAA.
REQ-039 KEY_DEPTH=16, six triples pushed with no pixels -> fifth accepted (level 15? no: level reaches 15 after five), sixth dropped, key_level=15, overflow=1 and remains 1.
REQ-040 out_ready held 0 for 5 cycles with pixels waiting -> out_data stable, pix_ready=0, no key popped; release -> stream resumes in order with no gaps or duplicates.
REQ-041 Push and pixel transfer in the same cycle at key_level=13 -> key_level=15 next cycle, byte order preserved across pointer wrap.

Source files
------------

// File: rtl/chaos_keystream_xor.sv
// Chaotic-map keystream cipher: folds float32 state words into key bytes, buffers
// them in a byte FIFO and XORs them onto pixels, optionally with cipher chaining.
module chaos_keystream_xor #(
  parameter int PRECISION = 32,
  parameter int KEY_DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [PRECISION-1:0]       x0,
  input  logic [PRECISION-1:0]       x1,
  input  logic [PRECISION-1:0]       x2,
  output logic                       in_ready,
  input  logic                       pix_valid,
  input  logic [7:0]                 pix_data,
  input  logic                       pix_sof,
  input  logic                       pix_last,
  output logic                       pix_ready,
  input  logic                       diffuse_en,
  input  logic [7:0]                 iv,
  output logic                       out_valid,
  output logic [7:0]                 out_data,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic                       overflow,
  output logic [$clog2(KEY_DEPTH):0] key_level
);

  localparam int AW = $clog2(KEY_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] PUSH_LIMIT = LW'(KEY_DEPTH - 3);

  // Only the mantissa carries usable entropy; sign and exponent are discarded.
  function automatic logic [7:0] key_byte(input logic [22:0] mant);
    return mant[7:0] ^ mant[15:8] ^ {1'b0, mant[22:16]};
  endfunction

  logic [7:0]    key_mem [KEY_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic [7:0]    c_prev_q, c_prev_d;
  logic          overflow_q, overflow_d;

  logic          push, drop, pop;
  logic [7:0]    k0, k1, k2, k_pop, chain, cipher;
  logic          unused_exp_bits;

  assign k0 = key_byte(x0[22:0]);
  assign k1 = key_byte(x1[22:0]);
  assign k2 = key_byte(x2[22:0]);
  assign unused_exp_bits = ^{x0[PRECISION-1:23], x1[PRECISION-1:23], x2[PRECISION-1:23]};

  // Both readies look only at registered state, so they never depend on each other.
  assign in_ready  = (level_q <= PUSH_LIMIT);
  assign pix_ready = (level_q != '0) && (!out_valid_q || out_ready);

  assign push = in_valid && in_ready;
  assign drop = in_valid && !in_ready;
  assign pop  = pix_valid && pix_ready;

  assign k_pop  = key_mem[rd_ptr_q];
  assign chain  = diffuse_en ? (pix_sof ? iv : c_prev_q) : 8'h00;
  assign cipher = pix_data ^ k_pop ^ chain;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    c_prev_d    = c_prev_q;
    overflow_d  = overflow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(3);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    level_d = level_q + (push ? LW'(3) : LW'(0)) - (pop ? LW'(1) : LW'(0));

    if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = cipher;
      out_last_d  = pix_last;
      c_prev_d    = cipher;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
      c_prev_q    <= 8'h00;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      c_prev_q    <= c_prev_d;
      overflow_q  <= overflow_d;
    end
  end

  // NOTE: the key storage is deliberately not reset; the pointers and level
  // define which entries are valid, so clearing the array buys nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      key_mem[wr_ptr_q]          <= k0;
      key_mem[wr_ptr_q + AW'(1)] <= k1;
      key_mem[wr_ptr_q + AW'(2)] <= k2;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign overflow  = overflow_q;
  assign key_level = level_q;

endmodule
